sp_mem_arb: RTL and testbench

Parametrised single-port memory shared by NUM_PORTS requesters through a round-robin arbiter with valid/ready handshakes.
- Adds per-lane write masks and a configurable read-return pipeline, with each read tagged by requesting port.
- Serves as the common storage block for datapath units that time-share one RAM macro, for example operand and result buffers of the field-arithmetic engines.
- One memory access per cycle, read or write, as before.

---
 rtl/sp_mem_arb_pkg.sv | 19 +
 rtl/sp_mem_arb_rr_arbiter.sv | 41 ++++
 rtl/sp_mem_arb.sv | 138 +++++++++++++
 tb/tb_sp_mem_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_mem_arb_pkg.sv
// Shared definitions for the sp_mem_arb slice: a clog2 helper macro that never
// returns zero, and the even-parity helper for one write lane.
`ifndef SP_MEM_ARB_PKG_SV
`define SP_MEM_ARB_PKG_SV

`define CLOG2(x) (((x) <= 1) ? 1 : $clog2(x))

package sp_mem_arb_pkg;

   localparam int MAX_LANE_W = 64;

   // Callers zero-extend narrower lanes, which leaves the parity unchanged.
   function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane);
      return ^lane;
   endfunction

endpackage

`endif

// File: rtl/sp_mem_arb_rr_arbiter.sv
// Round-robin arbiter: the scan starts at rr_ptr, and the pointer moves past the
// winner on every accepted transfer. No grant is issued while reset is asserted.
module rr_arbiter #(
   parameter  int N  = 2,
   localparam int PW = `CLOG2(N)
) (
   input  logic          clock,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [PW-1:0] grant_idx
);

   logic [PW-1:0] rr_ptr;
   logic          found;
   int            idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(rr_ptr) + k) % N;
         if (!found && rst_n && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = PW'(idx);
            found      = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= '0;
      else if (advance && found)
         rr_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/sp_mem_arb.sv
// Single-port RAM shared by NUM_PORTS requesters, with lane write masks and a
// tagged read-return pipeline. Defining SP_MEM_PARITY_EN adds per-lane parity
// storage and the parity_err output.
module sp_mem_arb import sp_mem_arb_pkg::*; #(
   parameter  int WIDTH        = 64,
   parameter  int DEPTH        = 64,
   parameter  int NUM_PORTS    = 2,
   parameter  int LANE_WIDTH   = 8,
   parameter  int READ_LATENCY = 2,
   localparam int LANES        = WIDTH / LANE_WIDTH,
   localparam int AW           = `CLOG2(DEPTH),
   localparam int PW           = `CLOG2(NUM_PORTS)
) (
   input  logic                         clock,
   input  logic                         rst_n,
   input  logic [NUM_PORTS-1:0]         req_valid,
   output logic [NUM_PORTS-1:0]         req_ready,
   input  logic [NUM_PORTS-1:0]         req_wr,
   input  logic [NUM_PORTS*AW-1:0]      req_addr,
   input  logic [NUM_PORTS*WIDTH-1:0]   req_data,
   input  logic [NUM_PORTS*LANES-1:0]   req_mask,
   output logic                         rd_valid,
   output logic [PW-1:0]                rd_port,
   output logic [WIDTH-1:0]             rd_data
`ifdef SP_MEM_PARITY_EN
  ,output logic                         parity_err
`endif
);

`ifdef SP_MEM_PARITY_EN
   localparam int ARR_W = WIDTH + LANES;
`else
   localparam int ARR_W = WIDTH;
`endif

   logic [NUM_PORTS-1:0] grant;
   logic [PW-1:0]        gidx;
   logic                 xfer;
   logic                 rd_accept;
   logic                 sel_wr;
   logic [AW-1:0]        sel_addr;
   logic [WIDTH-1:0]     sel_data;
   logic [LANES-1:0]     sel_mask;
   logic                 in_range;
   logic [ARR_W-1:0]     rd_word;

   logic [ARR_W-1:0]     mem [DEPTH];

   logic                 s_valid [READ_LATENCY];
   logic [PW-1:0]        s_port  [READ_LATENCY];
   logic [WIDTH-1:0]     s_data  [READ_LATENCY];

   rr_arbiter #(.N(NUM_PORTS)) u_arb (
      .clock     (clock),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (xfer),
      .grant     (grant),
      .grant_idx (gidx)
   );

   assign req_ready = grant;
   assign xfer      = |(req_valid & grant);
   assign sel_wr    = req_wr[gidx];
   assign sel_addr  = req_addr[int'(gidx)*AW +: AW];
   assign sel_data  = req_data[int'(gidx)*WIDTH +: WIDTH];
   assign sel_mask  = req_mask[int'(gidx)*LANES +: LANES];
   assign in_range  = (32'(sel_addr) < 32'(DEPTH));
   assign rd_accept = xfer & ~sel_wr;
   // Out-of-range reads return all zeros, which also keeps their parity clean.
   assign rd_word   = in_range ? mem[sel_addr] : '0;

   always_ff @(posedge clock) begin
      if (xfer && sel_wr && in_range) begin
         for (int k = 0; k < LANES; k++) begin
            if (sel_mask[k]) begin
               mem[sel_addr][k*LANE_WIDTH +: LANE_WIDTH] <= sel_data[k*LANE_WIDTH +: LANE_WIDTH];
`ifdef SP_MEM_PARITY_EN
               mem[sel_addr][WIDTH+k] <= lane_parity(MAX_LANE_W'(sel_data[k*LANE_WIDTH +: LANE_WIDTH]));
`endif
            end
         end
      end
   end

`ifdef SP_MEM_PARITY_EN
   logic rd_perr;
   logic s_perr [READ_LATENCY];

   always_comb begin
      rd_perr = 1'b0;
      for (int k = 0; k < LANES; k++)
         rd_perr = rd_perr |
                   (lane_parity(MAX_LANE_W'(rd_word[k*LANE_WIDTH +: LANE_WIDTH])) != rd_word[WIDTH+k]);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < READ_LATENCY; k++) s_perr[k] <= 1'b0;
      end else begin
         if (rd_accept) s_perr[0] <= rd_perr;
         for (int k = 1; k < READ_LATENCY; k++)
            if (s_valid[k-1]) s_perr[k] <= s_perr[k-1];
      end
   end

   assign parity_err = s_valid[READ_LATENCY-1] & s_perr[READ_LATENCY-1];
`endif

   // Each stage loads only behind a valid read, so the last stage holds its value.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < READ_LATENCY; k++) begin
            s_valid[k] <= 1'b0;
            s_port[k]  <= '0;
            s_data[k]  <= '0;
         end
      end else begin
         s_valid[0] <= rd_accept;
         if (rd_accept) begin
            s_port[0] <= gidx;
            s_data[0] <= rd_word[WIDTH-1:0];
         end
         for (int k = 1; k < READ_LATENCY; k++) begin
            s_valid[k] <= s_valid[k-1];
            if (s_valid[k-1]) begin
               s_port[k] <= s_port[k-1];
               s_data[k] <= s_data[k-1];
            end
         end
      end
   end

   assign rd_valid = s_valid[READ_LATENCY-1];
   assign rd_port  = s_port[READ_LATENCY-1];
   assign rd_data  = s_data[READ_LATENCY-1];

endmodule

// File: tb/tb_sp_mem_arb.sv
// Directed bench for sp_mem_arb: instance a uses the default parameters, and
// instance b uses DEPTH=40, READ_LATENCY=3. Both instances share the same stimulus.
module tb_sp_mem_arb;

   localparam int NP = 2;
   localparam int W  = 64;
   localparam int AW = 6;
   localparam int LN = 8;

   logic             clock = 1'b0;
   logic             rst_n = 1'b0;
   logic [NP-1:0]    req_valid = '0;
   logic [NP-1:0]    req_wr    = '0;
   logic [NP*AW-1:0] req_addr  = '0;
   logic [NP*W-1:0]  req_data  = '0;
   logic [NP*LN-1:0] req_mask  = '0;

   logic [NP-1:0]    req_ready_a, req_ready_b;
   logic             rd_valid_a, rd_valid_b;
   logic             rd_port_a, rd_port_b;
   logic [W-1:0]     rd_data_a, rd_data_b;
   logic             perr_a, perr_b;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int          cyc;
      logic        port;
      logic [63:0] data;
      logic        perr;
   } ret_t;

   ret_t qa[$];
   ret_t qb[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   sp_mem_arb dut_a (
      .clock      (clock),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready_a),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_mask   (req_mask),
      .rd_valid   (rd_valid_a),
      .rd_port    (rd_port_a),
      .rd_data    (rd_data_a)
`ifdef SP_MEM_PARITY_EN
     ,.parity_err (perr_a)
`endif
   );

   sp_mem_arb #(.DEPTH(40), .READ_LATENCY(3)) dut_b (
      .clock      (clock),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready_b),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .req_mask   (req_mask),
      .rd_valid   (rd_valid_b),
      .rd_port    (rd_port_b),
      .rd_data    (rd_data_b)
`ifdef SP_MEM_PARITY_EN
     ,.parity_err (perr_b)
`endif
   );

`ifndef SP_MEM_PARITY_EN
   assign perr_a = 1'b0;
   assign perr_b = 1'b0;
`endif

   // Every returned read is logged with the cycle count at which it was seen.
   always @(negedge clock) begin
      ret_t r;
      if (rd_valid_a) begin
         r.cyc = cyc; r.port = rd_port_a; r.data = rd_data_a; r.perr = perr_a;
         qa.push_back(r);
      end
      if (rd_valid_b) begin
         r.cyc = cyc; r.port = rd_port_b; r.data = rd_data_b; r.perr = perr_b;
         qb.push_back(r);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one request on port p. gcyc is the cycle in which the grant is seen,
   // and the read returns READ_LATENCY cycles after it.
   task automatic issue(input int p, input logic wr, input int addr, input logic [63:0] data,
                        input logic [7:0] mask, output int gcyc);
      req_valid               = '0;
      req_valid[p]            = 1'b1;
      req_wr[p]               = wr;
      req_addr[p*AW +: AW]    = AW'(addr);
      req_data[p*W +: W]      = data;
      req_mask[p*LN +: LN]    = mask;
      @(negedge clock); #1;
      gcyc = cyc;
      chk("grant_a", 64'(req_ready_a), 64'(2'b01 << p));
      chk("grant_b", 64'(req_ready_b), 64'(2'b01 << p));
      @(posedge clock); #1;
   endtask

   task automatic idle();
      req_valid = '0;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      int g[4];
      int gd, gr0, gr1;

      // Reset with traffic driven: no grants and a quiet return path.
      rst_n     = 1'b0;
      req_valid = 2'b11;
      req_wr    = 2'b00;
      req_addr  = {6'd6, 6'd5};
      repeat (3) @(negedge clock);
      #1;
      chk("rst_ready_a", 64'(req_ready_a), 0);
      chk("rst_ready_b", 64'(req_ready_b), 0);
      chk("rst_rd_valid_a", 64'(rd_valid_a), 0);
      chk("rst_rd_data_a", rd_data_a, 0);
      chk("rst_rd_valid_b", 64'(rd_valid_b), 0);
      chk("rst_rd_data_b", rd_data_b, 0);

      // Both ports reading continuously: grants alternate, and returns follow two cycles later.
      rst_n = 1'b1;
      #1;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) begin
            @(negedge clock); #1;
         end
         if (c == 6) req_valid = '0;
         if (c < 6) chk("fair_grant", 64'(req_ready_a), (c % 2 == 0) ? 64'h1 : 64'h2);
         if (c >= 2) begin
            chk("fair_rd_valid", 64'(rd_valid_a), 1);
            chk("fair_rd_port", 64'(rd_port_a), 64'((c - 2) % 2));
         end
      end
      @(negedge clock); #1;
      chk("fair_rd_idle", 64'(rd_valid_a), 0);
      chk("fair_port_hold", 64'(rd_port_a), 1);
      wait_cycles(3);

      // Masked write: the second write updates only lanes 0..3.
      qa.delete(); qb.delete();
      issue(0, 1'b1, 3, 64'h1111_2222_3333_4444, 8'hFF, gd);
      issue(0, 1'b1, 3, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, gd);
      issue(0, 1'b0, 3, 64'h0, 8'h00, gd);
      idle();
      wait_cycles(5);
      chk("mask_cnt_a", 64'(qa.size()), 1);
      if (qa.size() >= 1) begin
         chk("mask_data_a", qa[0].data, 64'h1111_2222_CCCC_DDDD);
         chk("mask_lat_a", 64'(qa[0].cyc), 64'(gd + 2));
         chk("mask_port_a", 64'(qa[0].port), 0);
      end
      chk("mask_cnt_b", 64'(qb.size()), 1);
      if (qb.size() >= 1) begin
         chk("mask_data_b", qb[0].data, 64'h1111_2222_CCCC_DDDD);
         chk("mask_lat_b", 64'(qb[0].cyc), 64'(gd + 3));
      end
      chk("hold_valid_a", 64'(rd_valid_a), 0);
      chk("hold_data_a", rd_data_a, 64'h1111_2222_CCCC_DDDD);

      // Latency and ordering for 4 back-to-back reads on instance b (latency 3).
      qa.delete(); qb.delete();
      for (int i = 0; i < 4; i++) issue(1, 1'b1, i, 64'(i + 100), 8'hFF, gd);
      for (int i = 0; i < 4; i++) issue(1, 1'b0, i, 64'h0, 8'h00, g[i]);
      idle();
      wait_cycles(6);
      chk("lat_cnt_b", 64'(qb.size()), 4);
      for (int i = 0; i < 4 && i < qb.size(); i++) begin
         chk("lat_cyc_b", 64'(qb[i].cyc), 64'(g[i] + 3));
         chk("lat_data_b", qb[i].data, 64'(i + 100));
         chk("lat_port_b", 64'(qb[i].port), 1);
      end

      // Out-of-range access on instance b: the write is dropped and the read returns zero.
      qb.delete();
      issue(0, 1'b1, 39, 64'h0000_0039_0039_0039, 8'hFF, gd);
      issue(0, 1'b1, 45, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, gd);
      issue(0, 1'b0, 45, 64'h0, 8'h00, gr0);
      issue(0, 1'b0, 39, 64'h0, 8'h00, gr1);
      idle();
      wait_cycles(6);
      chk("oor_cnt_b", 64'(qb.size()), 2);
      if (qb.size() >= 2) begin
         chk("oor_data_b", qb[0].data, 64'h0);
         chk("oor_lat_b", 64'(qb[0].cyc), 64'(gr0 + 3));
         chk("oor_keep39_b", qb[1].data, 64'h0000_0039_0039_0039);
         chk("oor_lat39_b", 64'(qb[1].cyc), 64'(gr1 + 3));
      end

      // Reset with 2 reads in flight on instance b: both reads are dropped and memory survives.
      qb.delete();
      issue(0, 1'b0, 0, 64'h0, 8'h00, gd);
      issue(0, 1'b0, 1, 64'h0, 8'h00, gd);
      rst_n = 1'b0;
      idle();
      #1;
      chk("flight_rst_valid_b", 64'(rd_valid_b), 0);
      chk("flight_rst_data_b", rd_data_b, 64'h0);
      wait_cycles(2);
      @(negedge clock);
      rst_n = 1'b1;
      wait_cycles(6);
      chk("drop_cnt_b", 64'(qb.size()), 0);
      qa.delete(); qb.delete();
      issue(0, 1'b0, 2, 64'h0, 8'h00, gd);
      idle();
      wait_cycles(5);
      chk("survive_cnt_b", 64'(qb.size()), 1);
      if (qb.size() >= 1) chk("survive_data_b", qb[0].data, 64'd102);
      chk("survive_cnt_a", 64'(qa.size()), 1);
      if (qa.size() >= 1) chk("survive_data_a", qa[0].data, 64'd102);

`ifdef SP_MEM_PARITY_EN
      // Flipping one stored bit makes the parity check fire on that word only.
      qa.delete();
      issue(0, 1'b1, 10, 64'h0123_4567_89AB_CDEF, 8'hFF, gd);
      issue(0, 1'b1, 11, 64'hFEDC_BA98_7654_3210, 8'hFF, gd);
      idle();
      @(negedge clock);
      dut_a.mem[10][0] = ~dut_a.mem[10][0];
      issue(0, 1'b0, 10, 64'h0, 8'h00, gd);
      issue(0, 1'b0, 11, 64'h0, 8'h00, gd);
      idle();
      wait_cycles(5);
      chk("par_cnt_a", 64'(qa.size()), 2);
      if (qa.size() >= 2) begin
         chk("par_err_flip", 64'(qa[0].perr), 1);
         chk("par_err_clean", 64'(qa[1].perr), 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
